alu_pkt_ctrl: RTL

- Packet controller between the UART RX byte stream, the 8-bit streaming `alu`, and the UART TX byte stream.
- Parses a 4-byte header: opcode, reserved, length LSB, length MSB. Length is the total packet bytes, header included.
- Drives the opcode to the ALU and sequences each payload byte through it, one byte in flight at a time.
- Forwards each ALU result to TX. Detects malformed packets and ALU stalls, and drains bad packets so RX framing stays aligned.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/alu_pkt_hdr.sv | 58 +++++
 rtl/alu_pkt_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU packet controller.
//   state_e     : controller FSM states
//   OP_*        : opcodes the streaming ALU understands
//   HDR_BYTES   : header length in bytes (opcode, reserved, len lo, len hi)
//   is_valid_op : true for opcodes the controller will forward to the ALU
package ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRsvd,
        StLenLo,
        StLenHi,
        StFeed,
        StAluReq,
        StCollect,
        StSend,
        StDrain
    } state_e;

    localparam logic [7:0] OP_PASS = 8'h01;
    localparam logic [7:0] OP_INC  = 8'h02;
    localparam logic [7:0] OP_NOT  = 8'h03;

    localparam int unsigned HDR_BYTES = 4;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_PASS) || (op == OP_INC) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/alu_pkt_hdr.sv
// Header capture for the ALU packet controller.
// Latches the opcode and the low length byte as they stream past, then
// combines the high length byte (presented live on rx_data_i) to produce the
// payload byte count and the header error decision.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   op_load_i       : capture rx_data_i as the opcode
//   len_lo_load_i   : capture rx_data_i as the low length byte
//   rx_data_i       : RX byte; treated as the high length byte by the outputs
//   op_o            : captured opcode (held until the next packet)
//   rem_o           : payload bytes (len - header), saturated at 0
//   len_short_o     : len is smaller than the header itself
//   op_bad_o        : captured opcode is not one the ALU supports
module alu_pkt_hdr
    import ctrl_pkg::*;
#(
    parameter int unsigned LenW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            op_load_i,
    input  logic            len_lo_load_i,
    input  logic [7:0]      rx_data_i,
    output logic [7:0]      op_o,
    output logic [LenW-1:0] rem_o,
    output logic            len_short_o,
    output logic            op_bad_o
);

    logic [7:0]      op_q, op_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [LenW-1:0] len;

    always_comb begin
        op_d     = op_load_i ? rx_data_i : op_q;
        len_lo_d = len_lo_load_i ? rx_data_i : len_lo_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= 8'h00;
            len_lo_q <= 8'h00;
        end else begin
            op_q     <= op_d;
            len_lo_q <= len_lo_d;
        end
    end

    // Only meaningful while the high length byte is on rx_data_i.
    always_comb begin
        len         = LenW'({rx_data_i, len_lo_q});
        len_short_o = len < LenW'(HDR_BYTES);
        rem_o       = len_short_o ? '0 : len - LenW'(HDR_BYTES);
        op_bad_o    = !is_valid_op(op_q);
    end

    assign op_o = op_q;

endmodule

// File: rtl/alu_pkt_ctrl.sv
// Packet controller between a UART RX byte stream, an 8-bit streaming ALU and
// a UART TX byte stream. Parses a 4-byte header (opcode, reserved, len lo,
// len hi; len counts the whole packet), then pushes each payload byte through
// the ALU one at a time and forwards each result to TX. Malformed packets and
// ALU stalls raise a one-cycle err_o pulse; remaining bytes of a bad packet
// are drained so the RX framing stays aligned.
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   rx_data_i, rx_valid_i, rx_ready_o : RX byte stream in
//   alu_op_o                         : opcode, stable for the whole packet
//   alu_data_o, alu_valid_o, alu_ready_i : operand stream to the ALU
//   alu_data_i, alu_valid_i, alu_ready_o : result stream from the ALU
//   tx_data_o, tx_valid_o, tx_ready_i : TX byte stream out
//   busy_o                           : packet in progress
//   err_o                            : one-cycle error pulse
module alu_pkt_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned AluTimeout = 256,
    parameter int unsigned LenW       = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] alu_op_o,
    output logic [7:0] alu_data_o,
    output logic       alu_valid_o,
    input  logic       alu_ready_i,
    input  logic [7:0] alu_data_i,
    input  logic       alu_valid_i,
    output logic       alu_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    state_e          state_q, state_d;
    logic [LenW-1:0] rem_q, rem_d, rem_dec;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      result_q, result_d;
    logic [31:0]     wait_q, wait_d;
    logic            err_q, err_d;
    logic            armed_q, armed_d;

    logic            op_load, len_lo_load;
    logic [LenW-1:0] hdr_rem;
    logic            hdr_short, hdr_op_bad;
    logic            timeout_hit, abort;

    alu_pkt_hdr #(
        .LenW(LenW)
    ) u_hdr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .op_load_i    (op_load),
        .len_lo_load_i(len_lo_load),
        .rx_data_i    (rx_data_i),
        .op_o         (alu_op_o),
        .rem_o        (hdr_rem),
        .len_short_o  (hdr_short),
        .op_bad_o     (hdr_op_bad)
    );

    // rem never wraps below zero.
    assign rem_dec = (rem_q == '0) ? '0 : rem_q - LenW'(1);

    // Fires on the last allowed waiting cycle, so the error pulse appears
    // exactly AluTimeout cycles after entering ALU_REQ or COLLECT.
    assign timeout_hit = (AluTimeout != 0) && (wait_q == 32'(AluTimeout - 1));

    // Holds rx_ready_o low while in reset and for the first cycle after it,
    // so every ready output reads 0 at reset.
    assign armed_d = 1'b1;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q    <= '0;
            hold_q   <= 8'h00;
            result_q <= 8'h00;
            wait_q   <= '0;
            err_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            hold_q   <= hold_d;
            result_q <= result_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            armed_q  <= armed_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        hold_d      = hold_q;
        result_d    = result_q;
        wait_d      = wait_q;
        err_d       = 1'b0;
        op_load     = 1'b0;
        len_lo_load = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid_i && armed_q) begin
                    op_load = 1'b1;
                    state_d = StRsvd;
                end
            end
            StRsvd: begin
                if (rx_valid_i) begin
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (rx_valid_i) begin
                    len_lo_load = 1'b1;
                    state_d     = StLenHi;
                end
            end
            StLenHi: begin
                if (rx_valid_i) begin
                    rem_d = hdr_rem;
                    if (hdr_short) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (hdr_op_bad) begin
                        // Unknown opcode: swallow the payload without the ALU.
                        err_d   = 1'b1;
                        state_d = (hdr_rem == '0) ? StIdle : StDrain;
                    end else if (hdr_rem == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                if (rx_valid_i) begin
                    hold_d  = rx_data_i;
                    wait_d  = '0;
                    state_d = StAluReq;
                end
            end
            StAluReq: begin
                if (alu_ready_i) begin
                    wait_d  = '0;
                    state_d = StCollect;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StCollect: begin
                if (alu_valid_i) begin
                    result_d = alu_data_i;
                    state_d  = StSend;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StSend: begin
                if (tx_ready_i) begin
                    rem_d   = rem_dec;
                    state_d = (rem_dec == '0) ? StIdle : StFeed;
                end
            end
            StDrain: begin
                if (rx_valid_i) begin
                    rem_d   = rem_dec;
                    state_d = (rem_dec == '0) ? StIdle : StDrain;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The byte stuck in the ALU counts as consumed; drain the rest.
        if (abort) begin
            err_d   = 1'b1;
            rem_d   = rem_dec;
            state_d = (rem_dec == '0) ? StIdle : StDrain;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs, decoded from state only
    // ---------------------------------------------------------------------
    always_comb begin
        rx_ready_o  = 1'b0;
        alu_valid_o = 1'b0;
        alu_ready_o = 1'b0;
        tx_valid_o  = 1'b0;

        unique case (state_q)
            StIdle:    rx_ready_o  = armed_q;
            StRsvd:    rx_ready_o  = 1'b1;
            StLenLo:   rx_ready_o  = 1'b1;
            StLenHi:   rx_ready_o  = 1'b1;
            StFeed:    rx_ready_o  = 1'b1;
            StAluReq:  alu_valid_o = 1'b1;
            StCollect: alu_ready_o = 1'b1;
            StSend:    tx_valid_o  = 1'b1;
            StDrain:   rx_ready_o  = 1'b1;
            default:   rx_ready_o  = 1'b0;
        endcase

        busy_o     = (state_q != StIdle);
        alu_data_o = hold_q;
        tx_data_o  = result_q;
        err_o      = err_q;
    end

endmodule
